// File: rtl/pipeline_stall_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_stall_controller_pkg
// Description : Shared opcode fields and state encoding for the stall controller.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_stall_controller_pkg;

    localparam logic [4:0] OPC_ALU   = 5'b00000;
    localparam logic [4:0] ALUOP_MUL = 5'b00110;
    localparam logic [4:0] ALUOP_DIV = 5'b00111;
    localparam logic [4:0] OPC_LW    = 5'b01000;

    localparam logic [0:0] ST_RUN     = 1'b0;
    localparam logic [0:0] ST_MD_WAIT = 1'b1;

    function automatic logic is_md_op(input logic [31:0] insn);
        return (insn[31:27] == OPC_ALU) &&
               ((insn[6:2] == ALUOP_MUL) || (insn[6:2] == ALUOP_DIV));
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter with increment enable that sticks at all-ones.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipeline_stall_controller.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_stall_controller
// Description : Prioritises branch flush, mult/div wait and load-use stall into
//               pipeline-register enables; owns the mult/div handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_stall_controller
    import pipeline_stall_controller_pkg::*;
#(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [31:0]      dx_insn,
    input  logic             load_use_hazard,
    input  logic             branch_taken,
    input  logic             md_result_rdy,
    output logic             pc_we,
    output logic             fd_we,
    output logic             dx_we,
    output logic             fd_flush,
    output logic             dx_flush,
    output logic             xm_bubble,
    output logic             ctrl_mult,
    output logic             ctrl_div,
    output logic             md_busy,
    output logic             md_timeout_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int                  c_wait_w    = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(MD_TIMEOUT - 1);

    logic [0:0]          r_state;
    logic [c_wait_w-1:0] r_wait_cnt;
    logic                r_ctrl_mult;
    logic                r_ctrl_div;
    logic                r_md_timeout_err;

    logic w_md_op;
    logic w_is_div;
    logic w_timeout;
    logic w_start;
    logic w_stall_inc;
    logic w_flush_inc;
    logic w_unused_insn;

    assign w_md_op       = is_md_op(dx_insn);
    assign w_is_div      = (dx_insn[6:2] == ALUOP_DIV);
    assign w_unused_insn = &{1'b0, dx_insn[26:7], dx_insn[1:0]};
    assign w_timeout     = (r_state == ST_MD_WAIT) && (r_wait_cnt == c_wait_last);
    assign w_start       = (r_state == ST_RUN) && !branch_taken && w_md_op;
    assign w_flush_inc   = (r_state == ST_RUN) && branch_taken;
    assign w_stall_inc   = !pc_we;

    always_comb begin
        pc_we     = 1'b1;
        fd_we     = 1'b1;
        dx_we     = 1'b1;
        fd_flush  = 1'b0;
        dx_flush  = 1'b0;
        xm_bubble = 1'b0;
        md_busy   = 1'b0;
        if (r_state == ST_RUN) begin
            if (branch_taken) begin
                fd_flush = 1'b1;
                dx_flush = 1'b1;
            end else if (w_md_op) begin
                pc_we     = 1'b0;
                fd_we     = 1'b0;
                dx_we     = 1'b0;
                xm_bubble = 1'b1;
            end else if (load_use_hazard) begin
                pc_we    = 1'b0;
                fd_we    = 1'b0;
                dx_flush = 1'b1;
            end
        end else begin
            md_busy = 1'b1;
            // A coincident result wins over the timeout, so it retires normally.
            if (!md_result_rdy && !w_timeout) begin
                pc_we     = 1'b0;
                fd_we     = 1'b0;
                dx_we     = 1'b0;
                xm_bubble = 1'b1;
            end else if (!md_result_rdy) begin
                dx_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state          <= ST_RUN;
            r_wait_cnt       <= '0;
            r_ctrl_mult      <= 1'b0;
            r_ctrl_div       <= 1'b0;
            r_md_timeout_err <= 1'b0;
        end else begin
            r_ctrl_mult <= 1'b0;
            r_ctrl_div  <= 1'b0;
            if (r_state == ST_RUN) begin
                if (w_start) begin
                    r_state     <= ST_MD_WAIT;
                    r_wait_cnt  <= '0;
                    r_ctrl_mult <= !w_is_div;
                    r_ctrl_div  <= w_is_div;
                end
            end else begin
                r_wait_cnt <= r_wait_cnt + c_wait_w'(1);
                if (md_result_rdy || w_timeout) begin
                    r_state <= ST_RUN;
                end
                if (w_timeout && !md_result_rdy) begin
                    r_md_timeout_err <= 1'b1;
                end
            end
        end
    end

    assign ctrl_mult      = r_ctrl_mult;
    assign ctrl_div       = r_ctrl_div;
    assign md_timeout_err = r_md_timeout_err;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .i_inc   (w_stall_inc),
        .o_count (stall_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .i_inc   (w_flush_inc),
        .o_count (flush_cnt)
    );

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stall_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_stall_controller
// Description : Directed and randomised checks of the stall controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_stall_controller;
    import pipeline_stall_controller_pkg::*;

    localparam int TO  = 8;
    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [31:0]   dx_insn = '0;
    logic          load_use_hazard = 1'b0;
    logic          branch_taken = 1'b0;
    logic          md_result_rdy = 1'b0;
    logic          pc_we, fd_we, dx_we, fd_flush, dx_flush, xm_bubble;
    logic          ctrl_mult, ctrl_div, md_busy, md_timeout_err;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int compared = 0;
    int mismatched = 0;

    // Reference model state
    bit m_wait, m_mul, m_div, m_err;
    int m_elapsed, m_stall, m_flush;

    pipeline_stall_controller #(
        .MD_TIMEOUT (TO),
        .CNT_W      (CW)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .dx_insn         (dx_insn),
        .load_use_hazard (load_use_hazard),
        .branch_taken    (branch_taken),
        .md_result_rdy   (md_result_rdy),
        .pc_we           (pc_we),
        .fd_we           (fd_we),
        .dx_we           (dx_we),
        .fd_flush        (fd_flush),
        .dx_flush        (dx_flush),
        .xm_bubble       (xm_bubble),
        .ctrl_mult       (ctrl_mult),
        .ctrl_div        (ctrl_div),
        .md_busy         (md_busy),
        .md_timeout_err  (md_timeout_err),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_insn(input logic [4:0] opc, input logic [4:0] aluop);
        logic [31:0] r;
        r       = $urandom;
        r[31:27] = opc;
        r[6:2]   = aluop;
        return r;
    endfunction

    function automatic logic [31:0] rand_insn();
        logic [31:0] r;
        case ($urandom_range(0, 3))
            0:       r = mk_insn(OPC_ALU, ALUOP_MUL);
            1:       r = mk_insn(OPC_ALU, ALUOP_DIV);
            2:       r = mk_insn(OPC_LW, 5'($urandom));
            default: r = $urandom;
        endcase
        return r;
    endfunction

    task automatic drive(input logic [31:0] insn, input logic lu, input logic br, input logic rdy);
        dx_insn         = insn;
        load_use_hazard = lu;
        branch_taken    = br;
        md_result_rdy   = rdy;
    endtask

    task automatic model_reset();
        m_wait = 0; m_mul = 0; m_div = 0; m_err = 0;
        m_elapsed = 0; m_stall = 0; m_flush = 0;
    endtask

    // Called at posedge+1; checks mid-cycle, advances the model at the edge.
    task automatic cycle();
        logic e_pc, e_fd, e_dx, e_fdf, e_dxf, e_bub, e_busy;
        bit   md, dv, tmo;
        #4;
        md  = (dx_insn[31:27] == 5'b00000) && (dx_insn[6:2] == 5'd6 || dx_insn[6:2] == 5'd7);
        dv  = (dx_insn[6:2] == 5'd7);
        tmo = m_wait && (m_elapsed == TO - 1);
        {e_pc, e_fd, e_dx, e_fdf, e_dxf, e_bub, e_busy} = 7'b1110000;
        if (!m_wait) begin
            if (branch_taken) begin
                e_fdf = 1; e_dxf = 1;
            end else if (md) begin
                {e_pc, e_fd, e_dx, e_bub} = 4'b0001;
            end else if (load_use_hazard) begin
                e_pc = 0; e_fd = 0; e_dxf = 1;
            end
        end else begin
            e_busy = 1;
            if (!md_result_rdy && !tmo) {e_pc, e_fd, e_dx, e_bub} = 4'b0001;
            else if (!md_result_rdy) e_dxf = 1;
        end
        check("pc_we", pc_we, e_pc);
        check("fd_we", fd_we, e_fd);
        check("dx_we", dx_we, e_dx);
        check("fd_flush", fd_flush, e_fdf);
        check("dx_flush", dx_flush, e_dxf);
        check("xm_bubble", xm_bubble, e_bub);
        check("md_busy", md_busy, e_busy);
        check("ctrl_mult", ctrl_mult, m_mul);
        check("ctrl_div", ctrl_div, m_div);
        check("md_timeout_err", md_timeout_err, m_err);
        check("stall_cnt", stall_cnt, m_stall);
        check("flush_cnt", flush_cnt, m_flush);
        @(posedge clock);
        if (!e_pc) m_stall = (m_stall < SAT) ? m_stall + 1 : SAT;
        if (!m_wait && branch_taken) m_flush = (m_flush < SAT) ? m_flush + 1 : SAT;
        m_mul = 0;
        m_div = 0;
        if (m_wait) begin
            if (md_result_rdy) m_wait = 0;
            else if (tmo) begin m_wait = 0; m_err = 1; end
            else m_elapsed++;
        end else if (!branch_taken && md) begin
            m_wait = 1; m_elapsed = 0; m_mul = !dv; m_div = dv;
        end
        #1;
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        model_reset();
        for (int i = 0; i < n; i++) begin
            drive(rand_insn(), 1'($urandom), 1'($urandom), 1'($urandom));
            #4;
            check("rst ctrl_mult", ctrl_mult, 0);
            check("rst ctrl_div", ctrl_div, 0);
            check("rst md_busy", md_busy, 0);
            check("rst md_timeout_err", md_timeout_err, 0);
            check("rst stall_cnt", stall_cnt, 0);
            check("rst flush_cnt", flush_cnt, 0);
            @(posedge clock);
            #1;
        end
        drive('0, 0, 0, 0);
        reset_n = 1'b1;
    endtask

    initial begin
        int pulses;
        logic [31:0] mul_i, div_i;

        #1;
        // Reset and idle
        do_reset(3);
        cycle();
        cycle();

        // Single load-use bubble
        drive(mk_insn(OPC_LW, 5'd0), 1, 0, 0);
        cycle();
        drive('0, 0, 0, 0);
        cycle();
        check("loaduse stall_cnt", stall_cnt, 1);

        // Multiply: result seven cycles into the wait
        do_reset(1);
        mul_i  = mk_insn(OPC_ALU, ALUOP_MUL);
        pulses = 0;
        drive(mul_i, 0, 0, 0);
        pulses += int'(ctrl_mult);
        cycle();
        for (int i = 0; i < 6; i++) begin
            pulses += int'(ctrl_mult);
            cycle();
        end
        drive(mul_i, 0, 0, 1);
        pulses += int'(ctrl_mult);
        cycle();
        drive('0, 0, 0, 0);
        pulses += int'(ctrl_mult);
        cycle();
        check("mult pulse count", pulses, 1);
        check("mult stall_cnt", stall_cnt, 7);
        check("mult busy after", md_busy, 0);

        // Divide with no result: abort on the eighth wait cycle
        do_reset(1);
        div_i = mk_insn(OPC_ALU, ALUOP_DIV);
        drive(div_i, 0, 0, 0);
        cycle();
        for (int i = 0; i < TO; i++) begin
            if (i == TO - 1) check("div err before abort", md_timeout_err, 0);
            cycle();
        end
        check("div err after abort", md_timeout_err, 1);
        drive('0, 0, 0, 0);
        cycle();
        check("div busy after abort", md_busy, 0);

        // Branch beats mult/div and load-use
        do_reset(1);
        drive(mk_insn(OPC_ALU, ALUOP_MUL), 1, 1, 0);
        cycle();
        drive('0, 0, 0, 0);
        cycle();
        check("prio flush_cnt", flush_cnt, 1);
        check("prio stall_cnt", stall_cnt, 0);

        // Saturation of the stall counter
        do_reset(1);
        drive(mk_insn(OPC_LW, 5'd0), 1, 0, 0);
        for (int i = 0; i < 20; i++) cycle();
        check("sat stall_cnt", stall_cnt, SAT);

        // Reset arriving mid-wait
        do_reset(1);
        drive(mk_insn(OPC_ALU, ALUOP_DIV), 0, 0, 0);
        cycle();
        cycle();
        drive(dx_insn, 0, 0, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst md_busy", md_busy, 0);
        check("midrst ctrl_div", ctrl_div, 0);
        @(posedge clock);
        #1;
        do_reset(1);
        cycle();

        // Randomised traffic
        do_reset(1);
        for (int i = 0; i < 400; i++) begin
            drive(rand_insn(), ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 4) == 0));
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
